// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte handoff and error pulses.
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset
//   uartRxPin  - serial line, idle high, asynchronous to clock
//   data       - received byte, meaningful while valid is high
//   valid      - high while data holds an unconsumed byte
//   ready      - consumer takes data on an edge where valid and ready are high
//   frameError - one-cycle pulse when the stop bit is sampled low
//   overrun    - one-cycle pulse when a byte completes while valid is still high
module uart_rx #(
    parameter int CLKS_PER_BIT = 210
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uartRxPin,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frameError,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_index;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uartRxPin;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_index  <= '0;
            shift      <= '0;
            data       <= 8'h00;
            valid      <= 1'b0;
            frameError <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frameError <= 1'b0;
            overrun    <= 1'b0;
            // a completing byte below may re-assert valid on this same edge
            if (valid && ready)
                valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_sync)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt       <= '0;
                        bit_index <= '0;
                        // a line back high at mid start bit is a glitch
                        state     <= rx_sync ? IDLE : DATA;
                    end else
                        cnt <= cnt + 1'b1;
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt              <= '0;
                        shift[bit_index] <= rx_sync;
                        bit_index        <= bit_index + 1'b1;
                        if (bit_index == 3'd7)
                            state <= STOP;
                    end else
                        cnt <= cnt + 1'b1;
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state <= IDLE;
                            if (!valid || ready) begin
                                data  <= shift;
                                valid <= 1'b1;
                            end else
                                overrun <= 1'b1;
                        end else begin
                            frameError <= 1'b1;
                            state      <= WAIT_HIGH;
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                WAIT_HIGH: begin
                    // a held-low break stays here without further error pulses
                    if (rx_sync)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 210 and 4 clocks per bit.
module tb_uart_rx;
    logic       clock = 1'b0;
    logic       reset;
    logic       rx, rx4;
    logic       ready, ready4;
    logic [7:0] data, data4;
    logic       valid, valid4;
    logic       frame_error, frame_error4;
    logic       overrun, overrun4;

    uart_rx #(.CLKS_PER_BIT(210)) u_dut (
        .clock(clock), .reset(reset), .uartRxPin(rx), .data(data), .valid(valid),
        .ready(ready), .frameError(frame_error), .overrun(overrun)
    );

    uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clock(clock), .reset(reset), .uartRxPin(rx4), .data(data4), .valid(valid4),
        .ready(ready4), .frameError(frame_error4), .overrun(overrun4)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;

    logic [7:0] q[$];
    logic [7:0] q4[$];
    int vcyc = 0, fe_n = 0, ov_n = 0, fe_run = 0, ov_run = 0;
    int fe4_n = 0, ov4_n = 0;
    logic pv = 1'b0, pfe = 1'b0, pov = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid && ready) q.push_back(data);
        if (valid4 && ready4) q4.push_back(data4);
        if (valid) vcyc++;
        if (valid && !pv) rise_cyc = cyc;
        if (frame_error) fe_n++;
        if (frame_error && pfe) fe_run++;
        if (overrun) ov_n++;
        if (overrun && pov) ov_run++;
        if (frame_error4) fe4_n++;
        if (overrun4) ov4_n++;
        pv  = valid;
        pfe = frame_error;
        pov = overrun;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic hold(input bit which, input logic v, input int n);
        if (which) rx4 = v;
        else rx = v;
        wait_cycles(n);
    endtask

    task automatic send(input bit which, input int cpb, input logic [7:0] b, input logic stop);
        if (which) rx4 = 1'b0;
        else begin
            rx = 1'b0;
            start_cyc = cyc;
        end
        wait_cycles(cpb);
        for (int i = 0; i < 8; i++) hold(which, b[i], cpb);
        hold(which, stop, cpb);
        if (which) rx4 = 1'b1;
        else rx = 1'b1;
    endtask

    int s_q, s_fe, s_ov, s_v, s4;

    initial begin
        reset = 1'b0;
        rx = 1'b1;
        rx4 = 1'b1;
        ready = 1'b1;
        ready4 = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_fe", 32'(frame_error), 32'h0);
        check("rst_ov", 32'(overrun), 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        wait_cycles(5);

        // single byte with ready held high
        s_q = q.size(); s_fe = fe_n; s_ov = ov_n; s_v = vcyc;
        send(0, 210, 8'hA5, 1'b1);
        wait_cycles(20);
        @(negedge clock);
        check("a5_count", 32'(q.size() - s_q), 32'd1);
        check("a5_data", 32'(q[q.size() - 1]), 32'hA5);
        check("a5_fe", 32'(fe_n - s_fe), 32'd0);
        check("a5_ov", 32'(ov_n - s_ov), 32'd0);
        check("a5_vcyc", 32'(vcyc - s_v), 32'd1);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'd1998);
        check("a5_valid_low", 32'(valid), 32'h0);
        wait_cycles(5);

        // back-to-back bytes while the consumer stalls
        ready = 1'b0;
        s_q = q.size(); s_ov = ov_n;
        send(0, 210, 8'h3C, 1'b1);
        send(0, 210, 8'h81, 1'b1);
        wait_cycles(20);
        @(negedge clock);
        check("ovr_data", 32'(data), 32'h3C);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_pulses", 32'(ov_n - s_ov), 32'd1);
        check("ovr_no_accept", 32'(q.size() - s_q), 32'd0);
        check("ovr_run", 32'(ov_run), 32'd0);
        @(posedge clock);
        #1 ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("ovr_valid_clr", 32'(valid), 32'h0);
        check("ovr_data_hold", 32'(data), 32'h3C);
        check("ovr_accepted", 32'(q[q.size() - 1]), 32'h3C);
        wait_cycles(5);

        // bad stop bit followed by a three-bit break, then a good frame
        s_fe = fe_n; s_ov = ov_n; s_v = vcyc;
        send(0, 210, 8'h55, 1'b0);
        hold(0, 1'b0, 630);
        hold(0, 1'b1, 420);
        @(negedge clock);
        check("fe_pulses", 32'(fe_n - s_fe), 32'd1);
        check("fe_no_valid", 32'(vcyc - s_v), 32'd0);
        check("fe_run", 32'(fe_run), 32'd0);
        check("fe_no_ov", 32'(ov_n - s_ov), 32'd0);
        wait_cycles(2);
        send(0, 210, 8'h0F, 1'b1);
        wait_cycles(20);
        @(negedge clock);
        check("fe_next_byte", 32'(q[q.size() - 1]), 32'h0F);
        wait_cycles(5);

        // short low glitch is rejected
        s_q = q.size(); s_fe = fe_n; s_ov = ov_n; s_v = vcyc;
        hold(0, 1'b0, 52);
        hold(0, 1'b1, 420);
        @(negedge clock);
        check("gl_valid", 32'(vcyc - s_v), 32'd0);
        check("gl_fe", 32'(fe_n - s_fe), 32'd0);
        check("gl_ov", 32'(ov_n - s_ov), 32'd0);
        wait_cycles(2);

        // reset in the middle of bit 4 of 8'hFF
        s_fe = fe_n; s_ov = ov_n; s_v = vcyc;
        hold(0, 1'b0, 210);
        for (int i = 0; i < 4; i++) hold(0, 1'b1, 210);
        hold(0, 1'b1, 100);
        reset = 1'b0;
        wait_cycles(3);
        @(negedge clock);
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_valid", 32'(valid), 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        wait_cycles(430);
        check("mid_rst_no_valid", 32'(vcyc - s_v), 32'd0);
        check("mid_rst_no_err", 32'(fe_n - s_fe + ov_n - s_ov), 32'd0);
        send(0, 210, 8'h12, 1'b1);
        wait_cycles(20);
        @(negedge clock);
        check("mid_rst_next", 32'(q[q.size() - 1]), 32'h12);
        wait_cycles(2);

        // minimum bit period, back-to-back frames
        s4 = q4.size();
        send(1, 4, 8'h00, 1'b1);
        send(1, 4, 8'hFF, 1'b1);
        wait_cycles(20);
        @(negedge clock);
        check("c4_count", 32'(q4.size() - s4), 32'd2);
        check("c4_first", 32'(q4.size() > s4 ? q4[s4] : 8'hxx), 32'h00);
        check("c4_second", 32'(q4.size() > s4 + 1 ? q4[s4 + 1] : 8'hxx), 32'hFF);
        check("c4_errors", 32'(fe4_n + ov4_n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 210, meaning clock cycles per serial bit period; legal range 4..4095.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 uartRxPin  input  1  serial line, idle high, asynchronous to clock.
REQ-005 data  output  8  received byte; meaningful only while valid=1.
REQ-006 valid  output  1  high while data holds an unconsumed byte.
REQ-007 ready  input  1  consumer accepts data on any rising edge where valid=1 and ready=1.
REQ-008 frameError  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: byte completed while previous byte still unconsumed.

Function
REQ-010 uartRxPin SHALL pass through a 2-flop synchronizer (rxSync); all decisions use rxSync only.
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: when rxSync=0, go to START with bit-period counter cleared to 0.
REQ-014 START: counter increments each cycle; at count CLKS_PER_BIT/2-1 (integer division) sample rxSync; 0 -> DATA, counter 0, bitIndex 0; 1 -> IDLE (glitch rejected, no outputs asserted).
REQ-015 DATA: at count CLKS_PER_BIT-1 sample rxSync into shift bit bitIndex, clear counter, increment bitIndex; after bitIndex 7 sampled go to STOP.
REQ-016 STOP: at count CLKS_PER_BIT-1 sample rxSync; 1 -> byte complete, go to IDLE; 0 -> frameError pulse, byte discarded, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rxSync=1, then go to IDLE; a held-low line (break) SHALL produce exactly one frameError pulse.
REQ-018 Byte-complete cycle: if valid=0, or valid=1 with ready=1 in the same cycle, load data with shifted byte and set valid=1 on the next edge.
REQ-019 Byte-complete cycle with valid=1 and ready=0: new byte discarded, data unchanged, valid stays 1, overrun pulses for one cycle.
REQ-020 valid=1 and ready=1 with no byte completing: valid clears on that edge; data holds its last value.
REQ-021 data and valid SHALL not change while valid=1 and ready=0 except via REQ-019 (no change).
REQ-022 Stop-sample edge SHALL occur CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after START entry; valid rises on that same edge.
REQ-023 Receiver SHALL accept a new start bit immediately after STOP->IDLE (back-to-back frames, no idle gap required).
REQ-024 frameError and overrun SHALL never be high for more than one consecutive cycle per event.
REQ-025 Counter width SHALL be $clog2(CLKS_PER_BIT) bits; counter SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-026 While reset=0: state IDLE, counter 0, bitIndex 0, synchronizer flops 1, data 8'h00, valid 0, frameError 0, overrun 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; no valid, frameError, or overrun results from the aborted frame.
REQ-028 After reset release with line low, receiver SHALL treat the low as a start edge (IDLE->START).

Verification
REQ-029 Send 8'hA5 at CLKS_PER_BIT=210, ready=1 -> valid pulses one cycle with data=8'hA5, frameError=0, overrun=0.
REQ-030 Send 8'h3C, then 8'h81 back-to-back, ready=0 -> data=8'h3C, valid held, overrun pulse once at second stop sample; after ready=1, valid clears, data=8'h3C.
REQ-031 Send 8'h55 with stop bit forced 0, line held low 3 bit periods -> frameError one pulse, valid stays 0; next frame 8'h0F received correctly.
REQ-032 Line low pulse of CLKS_PER_BIT/4 cycles -> START rejects, returns IDLE, no outputs assert.
REQ-033 Assert reset during bit 4 of 8'hFF -> all outputs at reset values; subsequent 8'h12 received correctly.
REQ-034 CLKS_PER_BIT=4, send 8'h00 and 8'hFF back-to-back with ready=1 -> both bytes delivered in order, no errors.
